health_ctrl: RTL and testbench
==============================

HEALTH_CTRL -- requirements
Module: health_ctrl

Interface
REQ-001 SHALL have parameter LIFE_W, default 4, width of the life counter.
REQ-002 SHALL have parameter LIFE_MAX, default 10, reset and heal-ceiling life value (1..2^LIFE_W-1).
REQ-003 SHALL have parameter DMG_W, default 2, width of the damage-amount input.
REQ-004 SHALL have parameter TICK_DIV, default 1000000, clock cycles per game tick (>=2).
REQ-005 SHALL have parameter INVULN_TICKS, default 8, ticks of invulnerability after a non-fatal hit (>=1).
REQ-006 SHALL have port clk, input, 1, system clock; every register is clocked on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port is_hit, input, 1, hit request, one clk-cycle pulse, synchronous to clk.
REQ-009 SHALL have port dmg, input, DMG_W, damage amount, sampled with is_hit; 0 is treated as 1.
REQ-010 SHALL have port heal, input, 1, heal request pulse, +1 life.
REQ-011 SHALL have port health, output, LIFE_W, current life, registered.
REQ-012 SHALL have port die, output, 1, sticky death flag, registered.
REQ-013 SHALL have port invuln, output, 1, high while in the INVULN state.
REQ-014 SHALL have port hurt, output, 1, one-cycle pulse on each accepted non-fatal or fatal hit.

Function
REQ-015 SHALL implement a three-state FSM: ALIVE, INVULN, DEAD.
REQ-016 SHALL generate an internal tick, one clk cycle wide, every TICK_DIV cycles, from a free-running counter that wraps at TICK_DIV-1 to 0.
REQ-017 SHALL, in ALIVE with is_hit=1, register health <= max(health - eff_dmg, 0) on the next edge, eff_dmg = (dmg==0) ? 1 : dmg; one-cycle latency.
REQ-018 SHALL, on an accepted hit with result 0, enter DEAD and assert die on the same edge health becomes 0.
REQ-019 SHALL, on an accepted hit with result >0, enter INVULN and load the invuln counter with INVULN_TICKS.
REQ-020 SHALL assert hurt for exactly the one cycle following each accepted hit.
REQ-021 SHALL, in INVULN, ignore is_hit entirely (no health change, no hurt) and decrement the invuln counter on each tick; on the tick that takes it to 0 return to ALIVE.
REQ-022 SHALL, in ALIVE or INVULN with heal=1 and no accepted hit, increment health saturating at LIFE_MAX.
REQ-023 SHALL, on simultaneous accepted hit and heal, apply the hit and discard the heal.
REQ-024 SHALL, in INVULN, apply heal normally while hits are ignored.
REQ-025 SHALL, in DEAD, ignore is_hit and heal; health holds 0, die holds 1 until rst.
REQ-026 SHALL compute the subtraction at LIFE_W+1 bits so no wrap-around occurs when eff_dmg > health.

Reset
REQ-027 SHALL on rst=1 asynchronously set state=ALIVE, health=LIFE_MAX, die=0, invuln=0, hurt=0, tick counter=0, invuln counter=0.
REQ-028 SHALL, on rst asserted mid-INVULN or in DEAD, abandon that state immediately; first hit after deassertion is accepted normally.

Structure
REQ-029 SHALL place the state encoding (ALIVE, INVULN, DEAD) and default parameter constants in shared package health_pkg.
REQ-030 SHALL implement the tick prescaler as sub-module tick_gen (parameter TICK_DIV; ports clk, rst, tick), reusable by other game blocks.
REQ-031 SHALL contain no logic clocked by anything other than clk.

Verification (TICK_DIV=4, INVULN_TICKS=2, LIFE_MAX=10, LIFE_W=4, DMG_W=2)
REQ-032 SHALL cover: reset, then is_hit, dmg=1 -> health 9 next cycle, hurt 1 cycle, invuln=1.
REQ-033 SHALL cover: hit during INVULN -> health unchanged, no hurt; after 2 ticks (<=8 cycles) invuln=0, then next hit accepted.
REQ-034 SHALL cover: health=2, is_hit dmg=3 -> health 0 (no wrap to 15), die=1, state DEAD; further heal/hit -> no change.
REQ-035 SHALL cover: health=10, heal -> stays 10; health=9 with simultaneous hit dmg=1 and heal in ALIVE -> 8.
REQ-036 SHALL cover: is_hit dmg=0 -> decrement by 1.
REQ-037 SHALL cover: rst asserted mid-INVULN and while DEAD -> outputs return to reset values without waiting for a clk edge.

Source files
------------

// File: rtl/health_pkg.sv
// Shared definitions for the player health controller and related game blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package health_pkg;

   typedef enum logic [1:0] {
      ST_ALIVE  = 2'd0,
      ST_INVULN = 2'd1,
      ST_DEAD   = 2'd2
   } state_t;

   localparam int DEF_LIFE_W       = 4;
   localparam int DEF_LIFE_MAX     = 10;
   localparam int DEF_DMG_W        = 2;
   localparam int DEF_TICK_DIV     = 1000000;
   localparam int DEF_INVULN_TICKS = 8;

endpackage

// File: rtl/tick_gen.sv
// Game-tick prescaler: one-cycle tick every TICK_DIV clocks from a free-running counter.
// Latency: tick is high during the cycle the counter sits at TICK_DIV-1.
// Backpressure: none, free-running.
module tick_gen #(
   parameter int TICK_DIV = health_pkg::DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   // Count 0..TICK_DIV-1 and wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/health_ctrl.sv
// Player health FSM: hits, heals, timed invulnerability and sticky death.
// Latency: hit/heal results appear one clock after the request; hurt pulses that same cycle.
// Backpressure: none; hits during INVULN/DEAD and heals during DEAD are dropped.
module health_ctrl
   import health_pkg::*;
#(
   parameter int LIFE_W       = DEF_LIFE_W,
   parameter int LIFE_MAX     = DEF_LIFE_MAX,
   parameter int DMG_W        = DEF_DMG_W,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int INVULN_TICKS = DEF_INVULN_TICKS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              is_hit,
   input  logic [DMG_W-1:0]  dmg,
   input  logic              heal,
   output logic [LIFE_W-1:0] health,
   output logic              die,
   output logic              invuln,
   output logic              hurt
);

   localparam int                INV_W    = $clog2(INVULN_TICKS + 1);
   localparam logic [INV_W-1:0]  INV_LOAD = INV_W'(INVULN_TICKS);
   localparam logic [LIFE_W-1:0] LIFE_TOP = LIFE_W'(LIFE_MAX);

   state_t            r_state;
   logic [INV_W-1:0]  r_inv_cnt;
   logic [LIFE_W-1:0] r_health;
   logic              r_die;
   logic              r_invuln;
   logic              r_hurt;

   logic              w_tick;
   logic [DMG_W-1:0]  w_eff_dmg;
   logic [LIFE_W:0]   w_diff;
   logic              w_fatal;
   logic              w_heal_ok;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // A zero damage request still costs one life.
   assign w_eff_dmg = (dmg == '0) ? DMG_W'(1) : dmg;
   // One extra bit so an overkill hit shows up as a borrow instead of wrapping.
   assign w_diff    = {1'b0, r_health} - (LIFE_W + 1)'(w_eff_dmg);
   assign w_fatal   = w_diff[LIFE_W] || (w_diff == '0);
   assign w_heal_ok = heal && (r_health < LIFE_TOP);

   // Health state machine; all outputs are registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_ALIVE;
         r_inv_cnt <= '0;
         r_health  <= LIFE_TOP;
         r_die     <= 1'b0;
         r_invuln  <= 1'b0;
         r_hurt    <= 1'b0;
      end else begin
         r_hurt <= 1'b0;
         case (r_state)
            ST_ALIVE: begin
               if (is_hit) begin
                  // Hit wins over a same-cycle heal.
                  r_hurt <= 1'b1;
                  if (w_fatal) begin
                     r_health <= '0;
                     r_die    <= 1'b1;
                     r_state  <= ST_DEAD;
                  end else begin
                     r_health  <= w_diff[LIFE_W-1:0];
                     r_invuln  <= 1'b1;
                     r_inv_cnt <= INV_LOAD;
                     r_state   <= ST_INVULN;
                  end
               end else if (w_heal_ok) begin
                  r_health <= r_health + LIFE_W'(1);
               end
            end
            ST_INVULN: begin
               if (w_heal_ok) begin
                  r_health <= r_health + LIFE_W'(1);
               end
               if (w_tick) begin
                  if (r_inv_cnt <= INV_W'(1)) begin
                     r_inv_cnt <= '0;
                     r_invuln  <= 1'b0;
                     r_state   <= ST_ALIVE;
                  end else begin
                     r_inv_cnt <= r_inv_cnt - INV_W'(1);
                  end
               end
            end
            ST_DEAD: begin
               r_health <= '0;
               r_die    <= 1'b1;
               r_invuln <= 1'b0;
            end
            default: begin
               r_state <= ST_ALIVE;
            end
         endcase
      end
   end

   assign health = r_health;
   assign die    = r_die;
   assign invuln = r_invuln;
   assign hurt   = r_hurt;

endmodule

// File: tb/tb_health_ctrl.sv
// Scoreboard bench for health_ctrl with TICK_DIV=4, INVULN_TICKS=2, LIFE_MAX=10.
// Expectations are tagged with the clock count at which they must hold.
// A negedge monitor pops and compares them independently of the stimulus.
module tb_health_ctrl;

   logic       clk;
   logic       rst;
   logic       is_hit;
   logic [1:0] dmg;
   logic       heal;
   logic [3:0] health;
   logic       die;
   logic       invuln;
   logic       hurt;

   typedef struct {
      int         cyc;
      string      name;
      logic [3:0] h;
      logic       d;
      logic       i;
      logic       u;
   } exp_t;

   exp_t q[$];
   int   cyc;
   int   n_checks;
   int   n_errors;
   bit   stim_done;

   health_ctrl #(
      .LIFE_W       (4),
      .LIFE_MAX     (10),
      .DMG_W        (2),
      .TICK_DIV     (4),
      .INVULN_TICKS (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .is_hit (is_hit),
      .dmg    (dmg),
      .heal   (heal),
      .health (health),
      .die    (die),
      .invuln (invuln),
      .hurt   (hurt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         n_checks++;
         if (e.cyc < cyc) begin
            n_errors++;
            $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
         end else if (health !== e.h || die !== e.d || invuln !== e.i || hurt !== e.u) begin
            n_errors++;
            $display("FAIL %s: got health=%0d die=%0b invuln=%0b hurt=%0b, expected health=%0d die=%0b invuln=%0b hurt=%0b",
                     e.name, health, die, invuln, hurt, e.h, e.d, e.i, e.u);
         end
      end
   end

   task automatic expect_now(input string name, input int h, input bit d, input bit i, input bit u);
      exp_t e;
      e.cyc  = cyc;
      e.name = name;
      e.h    = 4'(h);
      e.d    = d;
      e.i    = i;
      e.u    = u;
      q.push_back(e);
   endtask

   // Apply one request for one clock; returns just after the sampling edge.
   task automatic drive(input bit hit_i, input int dmg_i, input bit heal_i);
      is_hit = hit_i;
      dmg    = 2'(dmg_i);
      heal   = heal_i;
      @(posedge clk);
      #1;
      is_hit = 1'b0;
      dmg    = 2'd0;
      heal   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      cyc       = 0;
      n_checks  = 0;
      n_errors  = 0;
      stim_done = 1'b0;
      rst       = 1'b1;
      is_hit    = 1'b0;
      dmg       = 2'd0;
      heal      = 1'b0;

      idle(1);
      expect_now("reset", 10, 0, 0, 0);
      idle(1);
      rst = 1'b0;
      expect_now("post_reset", 10, 0, 0, 0);

      // Tick counter restarts at 0 here; ticks land on cycles 6, 10, 14, ...
      drive(1, 1, 0);  expect_now("hit_dmg1", 9, 0, 1, 1);
      drive(1, 2, 0);  expect_now("hit_in_invuln", 9, 0, 1, 0);
      drive(0, 0, 1);  expect_now("heal_in_invuln", 10, 0, 1, 0);
      idle(1);         expect_now("invuln_first_tick", 10, 0, 1, 0);
      idle(3);         expect_now("invuln_before_second_tick", 10, 0, 1, 0);
      idle(1);         expect_now("invuln_exit", 10, 0, 0, 0);
      drive(0, 0, 1);  expect_now("heal_saturate", 10, 0, 0, 0);
      drive(1, 0, 0);  expect_now("hit_dmg0", 9, 0, 1, 1);
      idle(5);         expect_now("invuln_hold2", 9, 0, 1, 0);
      idle(1);         expect_now("invuln_exit2", 9, 0, 0, 0);
      drive(1, 1, 1);  expect_now("hit_and_heal", 8, 0, 1, 1);
      idle(7);         expect_now("invuln_exit3", 8, 0, 0, 0);
      drive(1, 3, 0);  expect_now("hit_dmg3", 5, 0, 1, 1);
      idle(1);         expect_now("invuln_hold3", 5, 0, 1, 0);
      idle(1);

      // Asynchronous reset while invulnerable, checked before any clock edge.
      #1;
      rst = 1'b1;
      expect_now("reset_mid_invuln", 10, 0, 0, 0);
      #5;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Tick counter restarted; ticks now on cycles 33, 37, 41, ...
      drive(1, 3, 0);  expect_now("hit_after_reset", 7, 0, 1, 1);
      idle(6);         expect_now("invuln_exit4", 7, 0, 0, 0);
      drive(1, 3, 0);  expect_now("hit_to_4", 4, 0, 1, 1);
      idle(7);         expect_now("invuln_exit5", 4, 0, 0, 0);
      drive(1, 2, 0);  expect_now("hit_to_2", 2, 0, 1, 1);
      idle(7);         expect_now("invuln_exit6", 2, 0, 0, 0);
      drive(1, 3, 0);  expect_now("fatal_no_wrap", 0, 1, 0, 1);
      drive(0, 0, 1);  expect_now("dead_heal_ignored", 0, 1, 0, 0);
      drive(1, 3, 0);  expect_now("dead_hit_ignored", 0, 1, 0, 0);
      idle(1);

      // Asynchronous reset while dead.
      #1;
      rst = 1'b1;
      expect_now("reset_while_dead", 10, 0, 0, 0);
      #5;
      rst = 1'b0;
      @(posedge clk);
      #1;
      drive(1, 1, 0);  expect_now("hit_after_dead_reset", 9, 0, 1, 1);

      // Let the monitor drain, bounded.
      for (int k = 0; k < 10 && q.size() > 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (q.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
      end
      stim_done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
